// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with starvation promotion and buffered console output
module mem_arbiter #(
    parameter int                   WORD_SIZE    = 20,
    parameter logic [WORD_SIZE-1:0] IO_ADDR      = 'h3fff,
    parameter int                   STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req_i,
    input  logic [WORD_SIZE-1:0] a_addr_i,
    input  logic                 a_write_i,
    input  logic [WORD_SIZE-1:0] a_wdata_i,
    input  logic                 b_req_i,
    input  logic [WORD_SIZE-1:0] b_addr_i,
    input  logic                 b_write_i,
    input  logic [WORD_SIZE-1:0] b_wdata_i,
    output logic                 a_gnt_o,
    output logic                 b_gnt_o,
    output logic                 a_rvalid_o,
    output logic                 b_rvalid_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_value_o,
    output logic                 mem_write_o,
    input  logic [WORD_SIZE-1:0] mem_value_i,
    output logic                 console_valid_o,
    output logic [7:0]           console_data_o,
    input  logic                 console_ready_i
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t     rd_owner;
    logic [7:0] starve_cnt;
    logic       promote_b;
    logic       a_io, b_io;
    logic       cons_stall;
    logic       elig_a, elig_b;

    logic                 sel_gnt;
    logic                 sel_write;
    logic [WORD_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 sel_io_wr;

    assign promote_b  = (starve_cnt == LIMIT);
    assign a_io       = a_write_i && (a_addr_i == IO_ADDR);
    assign b_io       = b_write_i && (b_addr_i == IO_ADDR);
    // The buffer can take a new byte when empty or when it drains this same cycle.
    assign cons_stall = console_valid_o && !console_ready_i;
    assign elig_a     = a_req_i && !(a_io && cons_stall);
    assign elig_b     = b_req_i && !(b_io && cons_stall);

    assign a_gnt_o = !reset && elig_a && (!promote_b || !elig_b);
    assign b_gnt_o = !reset && elig_b && (promote_b || !elig_a);

    always_comb begin
        sel_gnt   = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (b_gnt_o) begin
            sel_gnt   = 1'b1;
            sel_write = b_write_i;
            sel_addr  = b_addr_i;
            sel_wdata = b_wdata_i;
        end else if (a_gnt_o) begin
            sel_gnt   = 1'b1;
            sel_write = a_write_i;
            sel_addr  = a_addr_i;
            sel_wdata = a_wdata_i;
        end
    end

    assign sel_io_wr   = sel_gnt && sel_write && (sel_addr == IO_ADDR);
    assign mem_addr_o  = sel_addr;
    assign mem_value_o = sel_write ? sel_wdata : '0;
    assign mem_write_o = sel_gnt && sel_write && !sel_io_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (b_req_i && !b_gnt_o) begin
            if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 8'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else if (a_gnt_o && !a_write_i) begin
            rd_owner <= OWN_A;
        end else if (b_gnt_o && !b_write_i) begin
            rd_owner <= OWN_B;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign a_rvalid_o = (rd_owner == OWN_A);
    assign b_rvalid_o = (rd_owner == OWN_B);
    assign rdata_o    = mem_value_i;

    // A reload in the drain cycle wins, so the new byte replaces the consumed one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            console_valid_o <= 1'b0;
            console_data_o  <= '0;
        end else if (sel_io_wr) begin
            console_valid_o <= 1'b1;
            console_data_o  <= sel_wdata[7:0];
        end else if (console_valid_o && console_ready_i) begin
            console_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_i, b_req_i, a_write_i, b_write_i;
    logic [19:0] a_addr_i, b_addr_i, a_wdata_i, b_wdata_i;
    logic        a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o;
    logic [19:0] rdata_o, mem_addr_o, mem_value_o, mem_value_i;
    logic        mem_write_o;
    logic        console_valid_o, console_ready_i;
    logic [7:0]  console_data_o;

    int total = 0;
    int bad   = 0;

    logic [19:0] mem [0:16383];

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(20), .IO_ADDR(20'h3fff), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_write_i(a_write_i), .a_wdata_i(a_wdata_i),
        .b_req_i(b_req_i), .b_addr_i(b_addr_i), .b_write_i(b_write_i), .b_wdata_i(b_wdata_i),
        .a_gnt_o(a_gnt_o), .b_gnt_o(b_gnt_o), .a_rvalid_o(a_rvalid_o), .b_rvalid_o(b_rvalid_o),
        .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_value_o(mem_value_o),
        .mem_write_o(mem_write_o), .mem_value_i(mem_value_i),
        .console_valid_o(console_valid_o), .console_data_o(console_data_o),
        .console_ready_i(console_ready_i)
    );

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_o) mem[mem_addr_o[13:0]] <= mem_value_o;
        mem_value_i <= mem[mem_addr_o[13:0]];
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        a_req_i = 0; a_write_i = 0; a_addr_i = '0; a_wdata_i = '0;
        b_req_i = 0; b_write_i = 0; b_addr_i = '0; b_wdata_i = '0;
    endtask

    task automatic test_reset;
        reset = 1; console_ready_i = 0;
        drive_idle();
        a_req_i = 1; b_req_i = 1;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b0 || b_gnt_o !== 1'b0) begin bad++; $display("FAIL reset_gnt got a=%b b=%b want 0 0", a_gnt_o, b_gnt_o); end
        total++; if (a_rvalid_o !== 1'b0 || b_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got a=%b b=%b want 0 0", a_rvalid_o, b_rvalid_o); end
        total++; if (console_valid_o !== 1'b0 || console_data_o !== 8'h00) begin bad++; $display("FAIL reset_console got v=%b d=%h want 0 00", console_valid_o, console_data_o); end
        total++; if (mem_write_o !== 1'b0 || mem_addr_o !== 20'h0) begin bad++; $display("FAIL reset_mem got w=%b addr=%h want 0 00000", mem_write_o, mem_addr_o); end
        next_cycle();
        reset = 0;
        drive_idle();
        next_cycle();
    endtask

    task automatic test_priority_a;
        a_req_i = 1; a_addr_i = 20'h0010;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b1 || b_gnt_o !== 1'b0) begin bad++; $display("FAIL prio_gnt got a=%b b=%b want 1 0", a_gnt_o, b_gnt_o); end
        total++; if (mem_addr_o !== 20'h0010) begin bad++; $display("FAIL prio_addr got %h want 00010", mem_addr_o); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        total++; if (a_rvalid_o !== 1'b1 || b_rvalid_o !== 1'b0) begin bad++; $display("FAIL prio_rvalid got a=%b b=%b want 1 0", a_rvalid_o, b_rvalid_o); end
        total++; if (rdata_o !== 20'h12345) begin bad++; $display("FAIL prio_rdata got %h want 12345", rdata_o); end
        next_cycle();
        @(negedge clk);
        total++; if (a_rvalid_o !== 1'b0) begin bad++; $display("FAIL prio_rvalid_pulse got %b want 0", a_rvalid_o); end
        next_cycle();
    endtask

    task automatic test_starvation;
        a_req_i = 1; a_addr_i = 20'h0010;
        b_req_i = 1; b_write_i = 1; b_addr_i = 20'h0020; b_wdata_i = 20'h0AAAA;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (a_gnt_o !== (c != 8) || b_gnt_o !== (c == 8)) begin
                bad++; $display("FAIL starve_c%0d got a=%b b=%b want %b %b", c, a_gnt_o, b_gnt_o, c != 8, c == 8);
            end
            if (c == 9) begin
                total++; if (dut.starve_cnt !== 8'd0) begin bad++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt); end
            end
            next_cycle();
            if (c == 8) begin b_req_i = 0; b_write_i = 0; end
        end
        drive_idle();
        a_req_i = 1; a_addr_i = 20'h0020;
        next_cycle();
        drive_idle();
        @(negedge clk);
        total++; if (a_rvalid_o !== 1'b1 || rdata_o !== 20'h0AAAA) begin bad++; $display("FAIL starve_readback got v=%b d=%h want 1 0aaaa", a_rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_console;
        a_req_i = 1; a_write_i = 1; a_addr_i = 20'h3fff; a_wdata_i = 20'h00041;
        console_ready_i = 0;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b1 || mem_write_o !== 1'b0) begin bad++; $display("FAIL con_first got gnt=%b memw=%b want 1 0", a_gnt_o, mem_write_o); end
        next_cycle();
        a_wdata_i = 20'h00042;
        @(negedge clk);
        total++; if (console_valid_o !== 1'b1 || console_data_o !== 8'h41) begin bad++; $display("FAIL con_latch got v=%b d=%h want 1 41", console_valid_o, console_data_o); end
        total++; if (a_gnt_o !== 1'b0) begin bad++; $display("FAIL con_blocked got gnt=%b want 0", a_gnt_o); end
        next_cycle();
        console_ready_i = 1;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b1 || console_data_o !== 8'h41) begin bad++; $display("FAIL con_drain_reload got gnt=%b d=%h want 1 41", a_gnt_o, console_data_o); end
        next_cycle();
        drive_idle();
        console_ready_i = 0;
        @(negedge clk);
        total++; if (console_valid_o !== 1'b1 || console_data_o !== 8'h42) begin bad++; $display("FAIL con_second got v=%b d=%h want 1 42", console_valid_o, console_data_o); end
        next_cycle();
        console_ready_i = 1;
        next_cycle();
        console_ready_i = 0;
        @(negedge clk);
        total++; if (console_valid_o !== 1'b0) begin bad++; $display("FAIL con_empty got v=%b want 0", console_valid_o); end
        a_req_i = 1; a_addr_i = 20'h3fff;
        next_cycle();
        drive_idle();
        @(negedge clk);
        total++; if (a_rvalid_o !== 1'b1 || rdata_o !== 20'h3abcd) begin bad++; $display("FAIL con_mem_kept got v=%b d=%h want 1 3abcd", a_rvalid_o, rdata_o); end
        next_cycle();
    endtask

    task automatic test_blocked_winner;
        a_req_i = 1; a_write_i = 1; a_addr_i = 20'h3fff; a_wdata_i = 20'h00055;
        next_cycle();
        a_wdata_i = 20'h00066;
        b_req_i = 1; b_addr_i = 20'h0005;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b0 || b_gnt_o !== 1'b1) begin bad++; $display("FAIL pass_gnt got a=%b b=%b want 0 1", a_gnt_o, b_gnt_o); end
        total++; if (mem_addr_o !== 20'h0005) begin bad++; $display("FAIL pass_addr got %h want 00005", mem_addr_o); end
        next_cycle();
        b_write_i = 1; b_addr_i = 20'h3fff; b_wdata_i = 20'h00077;
        @(negedge clk);
        total++; if (b_rvalid_o !== 1'b1 || a_rvalid_o !== 1'b0 || rdata_o !== 20'h00555) begin bad++; $display("FAIL pass_rdata got b=%b a=%b d=%h want 1 0 00555", b_rvalid_o, a_rvalid_o, rdata_o); end
        total++; if (a_gnt_o !== 1'b0 || b_gnt_o !== 1'b0) begin bad++; $display("FAIL both_blocked got a=%b b=%b want 0 0", a_gnt_o, b_gnt_o); end
        next_cycle();
        @(negedge clk);
        total++; if (dut.starve_cnt !== 8'd1) begin bad++; $display("FAIL both_blocked_cnt got %0d want 1", dut.starve_cnt); end
        total++; if (console_data_o !== 8'h55) begin bad++; $display("FAIL both_blocked_data got %h want 55", console_data_o); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid_read;
        b_req_i = 1; b_addr_i = 20'h0005;
        @(negedge clk);
        total++; if (b_gnt_o !== 1'b1) begin bad++; $display("FAIL midrd_gnt got %b want 1", b_gnt_o); end
        #2 reset = 1;
        next_cycle();
        drive_idle();
        a_req_i = 1; a_addr_i = 20'h0010;
        @(negedge clk);
        total++; if (b_rvalid_o !== 1'b0 || a_rvalid_o !== 1'b0) begin bad++; $display("FAIL midrd_rvalid got b=%b a=%b want 0 0", b_rvalid_o, a_rvalid_o); end
        total++; if (a_gnt_o !== 1'b0 || console_valid_o !== 1'b0 || console_data_o !== 8'h00) begin bad++; $display("FAIL midrd_outputs got gnt=%b v=%b d=%h want 0 0 00", a_gnt_o, console_valid_o, console_data_o); end
        next_cycle();
        reset = 0;
        @(negedge clk);
        total++; if (a_gnt_o !== 1'b1 || mem_addr_o !== 20'h0010) begin bad++; $display("FAIL post_gnt got gnt=%b addr=%h want 1 00010", a_gnt_o, mem_addr_o); end
        next_cycle();
        drive_idle();
        @(negedge clk);
        total++; if (a_rvalid_o !== 1'b1 || b_rvalid_o !== 1'b0 || rdata_o !== 20'h12345) begin bad++; $display("FAIL post_rdata got a=%b b=%b d=%h want 1 0 12345", a_rvalid_o, b_rvalid_o, rdata_o); end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] <= '0;
        mem[14'h0010] <= 20'h12345;
        mem[14'h0005] <= 20'h00555;
        mem[14'h3fff] <= 20'h3abcd;
        test_reset();
        test_priority_a();
        test_starvation();
        test_console();
        test_blocked_winner();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 20-bit word memory, with the console output device at 'h3fff moved out of the memory model. Port A is the CPU core and has fixed priority. Port B is the loader/debug engine and is protected from starvation by a wait counter. The block sits between the requesters and `memory`. It routes 1-cycle-latency read data back to whichever port issued the read, and buffers console writes behind a valid/ready handshake.

## Interface
- WORD_SIZE, 20, data and address width
- IO_ADDR, 'h3fff, console write address (decoded, never written to memory)
- STARVE_LIMIT, 8, consecutive refused B cycles before B is promoted (1..255)

- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high
- a_req_i / b_req_i  input  1  access request, held until granted
- a_addr_i / b_addr_i  input  WORD_SIZE  word address
- a_write_i / b_write_i  input  1  1 = write, 0 = read
- a_wdata_i / b_wdata_i  input  WORD_SIZE  write data
- a_gnt_o / b_gnt_o  output  1  access accepted this cycle (combinational)
- a_rvalid_o / b_rvalid_o  output  1  read data valid (registered)
- rdata_o  output  WORD_SIZE  read data, shared by both ports, qualified by the rvalid strobes
- mem_addr_o, mem_value_o, mem_write_o  output  WORD_SIZE/WORD_SIZE/1  to memory addr_i/value_i/write_i
- mem_value_i  input  WORD_SIZE  from memory value_o; valid the cycle after the address is presented
- console_valid_o  output  1  console byte pending
- console_data_o  output  8  pending byte (wdata[7:0])
- console_ready_i  input  1  console consumes the byte when valid and ready are both high

## Operation
- **Accepted access.** Each cycle at most one access is granted. A granted access drives mem_* in that same cycle.
- **Default priority.** A wins whenever `promote_b` = 0.
- **Starvation promotion.**
  - `starve_cnt` (8 bits) increments each cycle that b_req_i=1 and b_gnt_o=0.
  - It saturates at STARVE_LIMIT and clears whenever b_gnt_o=1 or b_req_i=0.
  - `promote_b` = (starve_cnt == STARVE_LIMIT). While it is set, B wins over A.
- **Blocked access.** An access is eligible only if it is not blocked. The only blocking case is a console write (write=1, addr==IO_ADDR) while the console buffer is full and console_ready_i=0. A blocked winner passes the grant to the other port if that port is eligible.
- **Console write.**
  - Sets console_valid_o and latches wdata[7:0].
  - mem_write_o stays 0.
  - A console write may be granted in the same cycle the buffer drains (valid & ready); the new byte replaces the old one.
- **Reads.** Reads of IO_ADDR go to memory like any other read.
- **Read tracking.** The registered `rd_owner` (none/A/B) records which port's read was granted last cycle. The matching rvalid is high for exactly one cycle. rdata_o = mem_value_i (combinational pass-through).
- **Writes.** Writes produce no rvalid.
- **Idle port.** When nothing is granted: mem_addr_o=0, mem_value_o=0, mem_write_o=0.

## Timing
- **Grant and memory drive.** Grant is combinational from the requests, `promote_b` and the console state. Memory is driven in the grant cycle.
- **Read latency.** Request granted at cycle N gives rvalid and data at cycle N+1. Back-to-back reads from alternating ports are supported, one per cycle.
- **Write latency.** Memory is updated at the posedge ending cycle N.
- **Console timing.** console_valid_o rises at N+1 after a granted console write. It falls on the posedge where valid & ready unless it is reloaded that same cycle.
- **Reset values.**
  - Outputs: a/b_rvalid_o=0, console_valid_o=0, console_data_o=0.
  - State: starve_cnt=0, rd_owner=none.
  - Grants are forced to 0 while reset is high.
- **Reset mid-read.** If reset is asserted while a read is outstanding, no rvalid is produced for it.
- **Starvation bound.** With A requesting continuously and B not blocked, B is granted within STARVE_LIMIT+1 cycles of raising b_req_i.
- **Both blocked.** If both ports issue a console write while the buffer is full and not ready: no grant, starve_cnt still counts.

## Test plan
- **Port A priority.** A reads 'h0010 (mem='h12345), B idle.
  - Cycle N: a_gnt=1, mem_addr='h0010.
  - Cycle N+1: a_rvalid=1, rdata='h12345, b_rvalid=0.
- **Starvation.** A requests every cycle; B writes 'h0AAAA to 'h0020 from cycle 0, STARVE_LIMIT=8.
  - Cycles 0-7: a_gnt=1, b_gnt=0.
  - Cycle 8: b_gnt=1, a_gnt=0.
  - Cycle 9: starve_cnt=0, a_gnt=1.
  - Readback of 'h0020 returns 'h0AAAA.
- **Console back-pressure.** A writes 'h00041 to IO_ADDR with console_ready=0.
  - Next cycle: console_valid=1, data='h41.
  - A second A write of 'h42 is not granted (a_gnt=0) while ready=0.
  - When ready=1: 'h41 is accepted and 'h42 is granted that same cycle. console_data='h42 the next cycle.
  - Memory word 'h3fff is unchanged.
- **Blocked winner passes grant.** Console buffer full, A writes IO_ADDR, B reads 'h0005.
  - b_gnt=1, a_gnt=0.
  - b_rvalid the next cycle with mem['h0005].
- **Reset mid-read.** Grant a B read, then assert reset on the next clock edge.
  - b_rvalid stays 0.
  - All outputs hold reset values.
  - After deassert, A read of 'h0010 returns 'h12345 with normal 1-cycle latency.
